// File: rtl/rvfpm_issue_ctrl_if.sv
// Core/FPU-facing bus of rvfpm_issue_ctrl: request handshake, FPU issue port,
// FPU result port and the retire outputs back to the core.
interface rvfpm_issue_ctrl_if #(
    parameter int XLEN       = 32,
    parameter int X_ID_WIDTH = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [31:0]           req_instr;
    logic [XLEN-1:0]       req_operand;

    logic                  fpu_ready;
    logic                  enable;
    logic [31:0]           instruction;
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       data_fromXreg;
    logic [XLEN-1:0]       data_fromMem;

    logic                  toXreg_valid;
    logic [XLEN-1:0]       data_toXreg;
    logic                  toMem_valid;
    logic [XLEN-1:0]       data_toMem;
    logic [X_ID_WIDTH-1:0] id_out;

    logic                  wb_valid;
    logic [4:0]            wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic                  st_valid;
    logic [X_ID_WIDTH-1:0] st_id;
    logic [XLEN-1:0]       st_data;
    logic                  err_spurious;
    logic [X_ID_WIDTH:0]   inflight_cnt;

    // The issue controller is the master: it drives the FPU and the retire outputs.
    modport master (
        input  req_valid, req_instr, req_operand, fpu_ready,
        input  toXreg_valid, data_toXreg, toMem_valid, data_toMem, id_out,
        output req_ready, enable, instruction, id, data_fromXreg, data_fromMem,
        output wb_valid, wb_rd, wb_data, st_valid, st_id, st_data,
        output err_spurious, inflight_cnt
    );

    modport slave (
        output req_valid, req_instr, req_operand, fpu_ready,
        output toXreg_valid, data_toXreg, toMem_valid, data_toMem, id_out,
        input  req_ready, enable, instruction, id, data_fromXreg, data_fromMem,
        input  wb_valid, wb_rd, wb_data, st_valid, st_id, st_data,
        input  err_spurious, inflight_cnt
    );
endinterface

// File: rtl/rvfpm_issue_ctrl.sv
// Core-side initiator for the rvfpm FPU: buffers requests, issues them with
// in-order transaction IDs and retires returned results as writebacks or stores.
module rvfpm_issue_ctrl #(
    parameter int XLEN        = 32,
    parameter int X_ID_WIDTH  = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                 ck,
    input  logic                 rst,
    rvfpm_issue_ctrl_if.master   bus
);
    localparam int              PTR_W      = $clog2(QUEUE_DEPTH);
    localparam int              NUM_IDS    = 1 << X_ID_WIDTH;
    localparam logic [PTR_W:0]  FULL_COUNT = QUEUE_DEPTH[PTR_W:0];
    localparam logic [6:0]      OP_LOAD    = 7'b0000011;
    localparam logic [6:0]      OP_FLOAD   = 7'b0000111;

    logic [31:0]           r_fifo_instr   [QUEUE_DEPTH];
    logic [XLEN-1:0]       r_fifo_operand [QUEUE_DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [PTR_W:0]        r_count;
    logic [X_ID_WIDTH-1:0] r_alloc_ptr;
    logic [NUM_IDS-1:0]    r_inflight;
    logic [4:0]            r_rd_table [NUM_IDS];
    logic [X_ID_WIDTH:0]   r_inflight_cnt;

    logic                  r_req_ready;
    logic                  r_enable;
    logic [31:0]           r_instruction;
    logic [X_ID_WIDTH-1:0] r_id;
    logic [XLEN-1:0]       r_data_fromXreg;
    logic [XLEN-1:0]       r_data_fromMem;
    logic                  r_wb_valid;
    logic [4:0]            r_wb_rd;
    logic [XLEN-1:0]       r_wb_data;
    logic                  r_st_valid;
    logic [X_ID_WIDTH-1:0] r_st_id;
    logic [XLEN-1:0]       r_st_data;
    logic                  r_err_spurious;

    logic                  w_push;
    logic                  w_issue;
    logic [31:0]           w_head_instr;
    logic [XLEN-1:0]       w_head_operand;
    logic [6:0]            w_opcode;
    logic                  w_is_load;
    logic                  w_any_result;
    logic                  w_hit;
    logic                  w_wb_hit;
    logic                  w_st_hit;
    logic [NUM_IDS-1:0]    w_set_mask;
    logic [NUM_IDS-1:0]    w_clr_mask;
    logic [NUM_IDS-1:0]    w_inflight_next;
    logic [PTR_W:0]        w_count_next;
    logic [X_ID_WIDTH:0]   w_inflight_cnt_next;

    assign w_push         = bus.req_valid & r_req_ready;
    assign w_head_instr   = r_fifo_instr[r_head];
    assign w_head_operand = r_fifo_operand[r_head];
    assign w_opcode       = w_head_instr[6:0];
    assign w_is_load      = (w_opcode == OP_LOAD) || (w_opcode == OP_FLOAD);

    // IDs go out strictly in order, so a busy alloc_ptr stalls issue even if others are free.
    assign w_issue        = (r_count != '0) && bus.fpu_ready && !r_inflight[r_alloc_ptr];

    assign w_any_result   = bus.toXreg_valid | bus.toMem_valid;
    assign w_hit          = w_any_result & r_inflight[bus.id_out];
    assign w_wb_hit       = bus.toXreg_valid & w_hit;
    assign w_st_hit       = bus.toMem_valid & w_hit;

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_issue) begin
            w_set_mask[r_alloc_ptr] = 1'b1;
        end
        if (w_hit) begin
            w_clr_mask[bus.id_out] = 1'b1;
        end
        w_inflight_next = (r_inflight | w_set_mask) & ~w_clr_mask;
    end

    always_comb begin
        w_count_next        = r_count;
        w_inflight_cnt_next = r_inflight_cnt;
        case ({w_push, w_issue})
            2'b10:   w_count_next = r_count + (PTR_W+1)'(1);
            2'b01:   w_count_next = r_count - (PTR_W+1)'(1);
            default: w_count_next = r_count;
        endcase
        case ({w_issue, w_hit})
            2'b10:   w_inflight_cnt_next = r_inflight_cnt + (X_ID_WIDTH+1)'(1);
            2'b01:   w_inflight_cnt_next = r_inflight_cnt - (X_ID_WIDTH+1)'(1);
            default: w_inflight_cnt_next = r_inflight_cnt;
        endcase
    end

    // Payload storage needs no reset: r_count and r_inflight decide what is valid.
    always_ff @(posedge ck) begin
        if (w_push) begin
            r_fifo_instr[r_tail]   <= bus.req_instr;
            r_fifo_operand[r_tail] <= bus.req_operand;
        end
        if (w_issue) begin
            r_rd_table[r_alloc_ptr] <= w_head_instr[11:7];
        end
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_alloc_ptr    <= '0;
            r_inflight     <= '0;
            r_inflight_cnt <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_issue) begin
                r_head      <= r_head + PTR_W'(1);
                r_alloc_ptr <= r_alloc_ptr + X_ID_WIDTH'(1);
            end
            r_count        <= w_count_next;
            r_inflight     <= w_inflight_next;
            r_inflight_cnt <= w_inflight_cnt_next;
        end
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            r_req_ready     <= 1'b0;
            r_enable        <= 1'b0;
            r_instruction   <= '0;
            r_id            <= '0;
            r_data_fromXreg <= '0;
            r_data_fromMem  <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_rd         <= '0;
            r_wb_data       <= '0;
            r_st_valid      <= 1'b0;
            r_st_id         <= '0;
            r_st_data       <= '0;
            r_err_spurious  <= 1'b0;
        end else begin
            r_req_ready     <= (w_count_next != FULL_COUNT);
            r_enable        <= w_issue;
            r_instruction   <= w_issue ? w_head_instr : '0;
            r_id            <= w_issue ? r_alloc_ptr : '0;
            r_data_fromXreg <= (w_issue && !w_is_load) ? w_head_operand : '0;
            r_data_fromMem  <= (w_issue && w_is_load) ? w_head_operand : '0;
            r_wb_valid      <= w_wb_hit;
            r_wb_rd         <= w_wb_hit ? r_rd_table[bus.id_out] : '0;
            r_wb_data       <= w_wb_hit ? bus.data_toXreg : '0;
            r_st_valid      <= w_st_hit;
            r_st_id         <= w_st_hit ? bus.id_out : '0;
            r_st_data       <= w_st_hit ? bus.data_toMem : '0;
            r_err_spurious  <= w_any_result & ~w_hit;
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.enable        = r_enable;
    assign bus.instruction   = r_instruction;
    assign bus.id            = r_id;
    assign bus.data_fromXreg = r_data_fromXreg;
    assign bus.data_fromMem  = r_data_fromMem;
    assign bus.wb_valid      = r_wb_valid;
    assign bus.wb_rd         = r_wb_rd;
    assign bus.wb_data       = r_wb_data;
    assign bus.st_valid      = r_st_valid;
    assign bus.st_id         = r_st_id;
    assign bus.st_data       = r_st_data;
    assign bus.err_spurious  = r_err_spurious;
    assign bus.inflight_cnt  = r_inflight_cnt;
endmodule
